// File: rtl/qos_drain_arbiter_if.sv
// qos_drain_arbiter_if: queue read strobes, queue data and the
// downstream valid/ready word bundle of the drain arbiter.
interface qos_drain_arbiter_if #(
  parameter int DSIZE = 32
);
  logic [4:0]       iEmpty;
  logic [DSIZE-1:0] iData0;
  logic [DSIZE-1:0] iData1;
  logic [DSIZE-1:0] iData2;
  logic [DSIZE-1:0] iData3;
  logic [DSIZE-1:0] iData4;
  logic [4:0]       oRd;
  logic             oValid;
  logic             iReady;
  logic [DSIZE-1:0] oData;
  logic [2:0]       oQid;

  modport master (
    input  iEmpty, iData0, iData1, iData2,
    input  iData3, iData4, iReady,
    output oRd, oValid, oData, oQid
  );

  modport slave (
    output iEmpty, iData0, iData1, iData2,
    output iData3, iData4, iReady,
    input  oRd, oValid, oData, oQid
  );
endinterface

// File: rtl/qos_drain_arbiter.sv
// qos_drain_arbiter: drains five queues one word at a time using
// strict priority, a weighted cap on queue 4 and age-based rescue.
module qos_drain_arbiter #(
  parameter int DSIZE     = 32,
  parameter int WEIGHT_HI = 4,
  parameter int AGE_MAX   = 15
) (
  input logic                 iClk,
  input logic                 iResetn,
  qos_drain_arbiter_if.master bus
);
  localparam int RW =
    (WEIGHT_HI < 2) ? 1 : $clog2(WEIGHT_HI + 1);
  localparam logic [3:0]    AMAX = 4'(AGE_MAX);
  localparam logic [RW-1:0] WMAX = RW'(WEIGHT_HI);

  typedef enum logic [1:0] {
    IDLE, ISSUE, CAPTURE, HOLD
  } state_t;

  state_t           state;
  logic [2:0]       rSel;
  logic [RW-1:0]    rHiRun;
  logic [3:0]       age [5];
  logic [4:0]       busy;
  logic [4:0]       starve;
  logic [2:0]       sel;
  logic [DSIZE-1:0] word;

  function automatic logic [2:0] top(
    input logic [4:0] v
  );
    logic [2:0] r;
    r = 3'd0;
    for (int n = 0; n < 5; n++)
      if (v[n]) r = 3'(n);
    return r;
  endfunction

  always_comb begin
    busy = ~bus.iEmpty;
    for (int n = 0; n < 5; n++)
      starve[n] = busy[n] && (age[n] == AMAX);
  end

  // starvation rescue first, then the queue-4 weight cap
  always_comb begin
    sel = 3'd0;
    priority case (1'b1)
      (|starve):
        sel = top(starve);
      ((rHiRun == WMAX) && (|busy[3:0])):
        sel = top({1'b0, busy[3:0]});
      default:
        sel = top(busy);
    endcase
  end

  always_comb begin
    word = bus.iData0;
    case (rSel)
      3'd1:    word = bus.iData1;
      3'd2:    word = bus.iData2;
      3'd3:    word = bus.iData3;
      3'd4:    word = bus.iData4;
      default: word = bus.iData0;
    endcase
  end

  always_ff @(posedge iClk or negedge iResetn) begin
    if (!iResetn) begin
      state      <= IDLE;
      rSel       <= 3'd0;
      rHiRun     <= '0;
      bus.oRd    <= 5'd0;
      bus.oValid <= 1'b0;
      bus.oData  <= '0;
      bus.oQid   <= 3'd0;
      for (int n = 0; n < 5; n++)
        age[n] <= 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|busy) begin
            state   <= ISSUE;
            rSel    <= sel;
            bus.oRd <= 5'b1 << sel;
            if (sel == 3'd4) begin
              if (rHiRun != WMAX)
                rHiRun <= rHiRun + 1'b1;
            end else begin
              rHiRun <= '0;
            end
            for (int n = 0; n < 5; n++) begin
              if (!busy[n] || sel == 3'(n))
                age[n] <= 4'd0;
              else if (age[n] < AMAX)
                age[n] <= age[n] + 4'd1;
            end
          end
        end
        ISSUE: begin
          bus.oRd <= 5'd0;
          state   <= CAPTURE;
        end
        CAPTURE: begin
          bus.oData  <= word;
          bus.oQid   <= rSel;
          bus.oValid <= 1'b1;
          state      <= HOLD;
        end
        HOLD: begin
          if (bus.iReady) begin
            bus.oValid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_qos_drain_arbiter.sv
// tb_qos_drain_arbiter: random and directed traffic against a
// queue-level reference model of the drain arbiter.
`timescale 1ns/1ps
module tb_qos_drain_arbiter;
  localparam int DW  = 32;
  localparam int WHI = 4;
  localparam int AMX = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  qos_drain_arbiter_if #(.DSIZE(DW)) bus ();
  qos_drain_arbiter_if #(.DSIZE(DW)) bus2 ();

  qos_drain_arbiter #(
    .DSIZE(DW), .WEIGHT_HI(WHI), .AGE_MAX(AMX)
  ) dut (
    .iClk(clk), .iResetn(rst_n), .bus(bus)
  );

  qos_drain_arbiter #(
    .DSIZE(DW), .WEIGHT_HI(255), .AGE_MAX(AMX)
  ) dut_w (
    .iClk(clk), .iResetn(rst_n), .bus(bus2)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          id;
    logic [31:0] w;
  } ent_t;

  ent_t        pend [$];
  int          cnt [5] = '{default: 0};
  logic [31:0] dq [5] = '{default: 0};
  int          grants [$];

  int          age_m [5] = '{default: 0};
  int          hirun_m = 0;
  bit          inflight = 0;
  bit          prev_valid = 0;
  int          lat = 0;
  int          stall = 0;
  logic [31:0] exp_w = 0;
  int          exp_q = 0;

  assign bus.iData0 = dq[0];
  assign bus.iData1 = dq[1];
  assign bus.iData2 = dq[2];
  assign bus.iData3 = dq[3];
  assign bus.iData4 = dq[4];

  task automatic push(input int id, input logic [31:0] w);
    ent_t e;
    e.id = id;
    e.w  = w;
    pend.push_back(e);
    cnt[id]++;
  endtask

  function automatic logic [31:0] take(input int id);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < pend.size(); i++) begin
      if (pend[i].id == id) begin
        r = pend[i].w;
        pend.delete(i);
        cnt[id]--;
        return r;
      end
    end
    return r;
  endfunction

  // selection rules applied to the empty vector seen at the grant
  function automatic int pick(input logic [4:0] emp);
    int r;
    r = -1;
    for (int n = 0; n < 5; n++)
      if (!emp[n] && age_m[n] >= AMX) r = n;
    if (r >= 0) return r;
    if (hirun_m >= WHI && emp[3:0] != 4'hf) begin
      for (int n = 0; n < 4; n++)
        if (!emp[n]) r = n;
      return r;
    end
    for (int n = 0; n < 5; n++)
      if (!emp[n]) r = n;
    return r;
  endfunction

  function automatic void account(
    input int s, input logic [4:0] emp
  );
    for (int n = 0; n < 5; n++) begin
      if (n == s || emp[n]) age_m[n] = 0;
      else if (age_m[n] < AMX) age_m[n]++;
    end
    if (s == 4) hirun_m = (hirun_m < WHI) ? hirun_m + 1 : WHI;
    else hirun_m = 0;
  endfunction

  // monitor runs 2ns after each rising edge
  always @(posedge clk) begin
    int          es;
    logic [4:0]  e;
    logic [31:0] w;
    #2;
    if (!rst_n) begin
      for (int n = 0; n < 5; n++) age_m[n] = 0;
      hirun_m    = 0;
      inflight   = 0;
      prev_valid = 0;
      lat        = 0;
      stall      = 0;
    end else begin
      if (prev_valid && bus.iReady) inflight = 0;
      if (bus.oRd != 5'd0) begin
        chk("rd_while_busy", 64'(inflight), 64'd0);
        es = pick(bus.iEmpty);
        chk("rd_select", 64'(bus.oRd),
            (es < 0) ? 64'd0 : (64'd1 << es));
        if (es >= 0) begin
          account(es, bus.iEmpty);
          grants.push_back(es);
          w        = take(es);
          dq[es]   = w;
          exp_w    = w;
          exp_q    = es;
          inflight = 1;
          lat      = 0;
        end
        stall = 0;
      end else if (inflight) begin
        lat++;
        if (lat == 1)
          chk("valid_early", 64'(bus.oValid), 64'd0);
        if (lat == 2) begin
          chk("valid", 64'(bus.oValid), 64'd1);
          chk("data", 64'(bus.oData), 64'(exp_w));
          chk("qid", 64'(bus.oQid), 64'(exp_q));
        end
      end else if (bus.iEmpty != 5'h1f) begin
        stall++;
        if (stall == 4) chk("stall", 64'(stall), 64'd0);
      end
      prev_valid = bus.oValid;
    end
    for (int n = 0; n < 5; n++) e[n] = (cnt[n] == 0);
    bus.iEmpty = e;
  end

  task automatic wait_idle(input int lim);
    int t;
    t = 0;
    bus.iReady = 1'b1;
    while ((pend.size() != 0 || inflight || bus.oValid)
           && t < lim) begin
      @(negedge clk);
      t++;
    end
    if (t >= lim) chk("drain_timeout", 64'(t), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_grants(input int n);
    int t;
    t = 0;
    while (grants.size() < n && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("grant_timeout", 64'(grants.size()), 64'(n));
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    while (!bus.oValid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("valid_timeout", 64'(bus.oValid), 64'd1);
  endtask

  initial begin
    int          exp31 [10];
    logic [31:0] w;
    int          t;
    int          n16;
    int          n4;
    logic [4:0]  g16;

    exp31 = '{4, 4, 4, 4, 0, 4, 4, 4, 4, 0};
    bus.iEmpty   = 5'h1f;
    bus.iReady   = 1'b0;
    bus2.iEmpty  = 5'h1f;
    bus2.iReady  = 1'b1;
    bus2.iData0  = '0;
    bus2.iData1  = '0;
    bus2.iData2  = 32'h2222_2222;
    bus2.iData3  = '0;
    bus2.iData4  = 32'h4444_4444;

    @(negedge clk);
    chk("rst_rd", 64'(bus.oRd), 64'd0);
    chk("rst_valid", 64'(bus.oValid), 64'd0);
    chk("rst_data", 64'(bus.oData), 64'd0);
    chk("rst_qid", 64'(bus.oQid), 64'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    repeat (20) begin
      @(negedge clk);
      chk("all_empty", 64'({bus.oRd, bus.oValid}), 64'd0);
    end

    bus.iReady = 1'b1;
    push(1, 32'hA5A5_0001);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (bus.oRd == 5'd0 && t < 20);
    chk("single_rd", 64'(bus.oRd), 64'h02);
    @(negedge clk);
    chk("single_rd_off", 64'({bus.oRd, bus.oValid}), 64'd0);
    @(negedge clk);
    chk("single_valid", 64'(bus.oValid), 64'd1);
    chk("single_data", 64'(bus.oData), 64'hA5A5_0001);
    chk("single_qid", 64'(bus.oQid), 64'd1);
    wait_idle(100);

    grants.delete();
    for (int i = 0; i < 12; i++) begin
      push(4, $urandom);
      push(0, $urandom);
    end
    wait_grants(10);
    for (int i = 0; i < 10; i++)
      chk("weight_seq", 64'(grants[i]), 64'(exp31[i]));
    wait_idle(400);

    bus.iReady = 1'b0;
    w = $urandom;
    push(3, w);
    wait_valid();
    repeat (10) begin
      @(negedge clk);
      chk("hold_stable",
          64'({bus.oRd, bus.oValid, bus.oQid, bus.oData}),
          64'({5'd0, 1'b1, 3'd3, w}));
    end
    bus.iReady = 1'b1;
    @(negedge clk);
    chk("hold_release", 64'(bus.oValid), 64'd0);
    wait_idle(100);

    bus.iReady = 1'b0;
    push(3, $urandom);
    wait_valid();
    push(1, $urandom);
    push(4, $urandom);
    repeat (2) @(negedge clk);
    chk("hold_qid_kept", 64'(bus.oQid), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_clear", 64'({bus.oValid, bus.oRd}), 64'd0);
    chk("async_data", 64'(bus.oData), 64'd0);
    grants.delete();
    @(negedge clk);
    bus.iReady = 1'b1;
    #1 rst_n = 1'b1;
    wait_grants(1);
    if (grants.size() > 0)
      chk("post_rst_grant", 64'(grants[0]), 64'd4);
    wait_idle(100);

    repeat (800) begin
      @(negedge clk);
      if ($urandom_range(0, 99) < 30) begin
        if ($urandom_range(0, 9) < 4) push(4, $urandom);
        else push($urandom_range(0, 3), $urandom);
      end
      bus.iReady = ($urandom_range(0, 3) != 0);
    end
    wait_idle(2000);

    @(negedge clk);
    bus2.iEmpty = 5'b01011;
    n16 = 0;
    n4  = 0;
    g16 = 5'd0;
    t   = 0;
    while (n16 < 16 && t < 200) begin
      @(negedge clk);
      t++;
      if (bus2.oRd != 5'd0) begin
        n16++;
        if (n16 < 16 && bus2.oRd == 5'b10000) n4++;
        if (n16 == 16) g16 = bus2.oRd;
      end
    end
    chk("age_hi_runs", 64'(n4), 64'd15);
    chk("age_rescue", 64'(g16), 64'h04);
    bus2.iEmpty = 5'h1f;

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
